fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter PC_W, 16, width of PC and all address ports.
REQ-002 The block SHALL have parameter INSTR_W, 16, width of an instruction word.
REQ-003 The block SHALL have parameter RESET_PC, 16'h0000, PC value loaded on reset.
REQ-004 The block SHALL have parameter NOP_INSTR, 16'h0000, word driven on id_instr for a bubble.
REQ-005 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1: one clock, reset asynchronous and active-low.
REQ-007 Port stall, input, 1: hazard stall; hold the PC and the IF/ID register.
REQ-008 Port kill, input, 1: redirect taken; flush IF/ID and load the redirect target.
REQ-009 Port pc_src, input, 2: redirect select (0 PC+1, 1 jump_target, 2 branch_target, 3 return_addr).
REQ-010 Ports jump_target, branch_target and return_addr SHALL each be inputs of width PC_W carrying redirect addresses.
REQ-011 Port imem_req, output, 1: instruction fetch request.
REQ-012 Port imem_addr, output, PC_W: fetch address.
REQ-013 Port imem_ready, input, 1: response strobe; imem_rdata is valid in this cycle.
REQ-014 Port imem_rdata, input, INSTR_W: fetched instruction.
REQ-015 Ports id_instr (INSTR_W), id_pc (PC_W), id_pc_plus1 (PC_W) and id_valid (1) SHALL be outputs forming the IF/ID register.
REQ-016 Port pc, output, PC_W: current fetch PC.

Function
REQ-017 The block SHALL implement FSM states BOOT, FETCH, HOLD and DROP.
REQ-018 BOOT SHALL last exactly one cycle after rst_n deasserts, with imem_req=0, and then go to FETCH.
REQ-019 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; the request SHALL stay asserted with a stable address until imem_ready.
REQ-020 FETCH with imem_ready=1, stall=0, kill=0: IF/ID <= {imem_rdata, pc, pc+1, valid=1}; pc <= pc+1; state stays FETCH. Throughput SHALL be 1 instruction/cycle when imem_ready is held high.
REQ-021 FETCH with imem_ready=1, stall=1, kill=0: imem_rdata SHALL be captured in a one-entry skid buffer; IF/ID and pc held; next state HOLD.
REQ-022 FETCH with imem_ready=0 and stall=1: IF/ID and pc SHALL hold; the request continues.
REQ-023 HOLD: imem_req=0; while stall=1 everything holds; on stall=0 and kill=0, IF/ID <= buffer contents with valid=1, pc <= pc+1, next state FETCH.
REQ-024 kill=1 SHALL override stall in every state: IF/ID <= {NOP_INSTR, id_pc held, id_pc_plus1 held, valid=0}, skid buffer discarded, pc <= target selected by pc_src.
REQ-025 kill=1 in FETCH with imem_ready=0 (request in flight) SHALL go to DROP; otherwise it SHALL go to FETCH.
REQ-026 DROP: imem_req=1 and imem_addr=the latched in-flight address (not pc); on imem_ready the data SHALL be discarded and the state SHALL go to FETCH; kill in DROP updates pc only.
REQ-027 kill=1 with pc_src=0 SHALL flush and load pc+1 (defined, not an error).
REQ-028 PC arithmetic SHALL be modulo 2^PC_W: 16'hFFFF+1 = 16'h0000; id_pc_plus1 wraps identically.
REQ-029 id_valid=0 SHALL imply id_instr=NOP_INSTR.
REQ-030 The outputs imem_req and imem_addr SHALL be decoded from registered state only, with no combinational path from stall, kill or imem_ready.

Reset
REQ-031 While rst_n=0, immediately and independent of clk: state=BOOT, pc=RESET_PC, imem_req=0, id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_pc_plus1=0, skid buffer empty.
REQ-032 Reset asserted mid-request (FETCH or DROP) SHALL drop imem_req in the same cycle; any later imem_ready SHALL be ignored until FETCH is re-entered after BOOT.

Verification
REQ-033 Reset then imem_ready held 1 with rdata = address: after BOOT, id_instr shows 0,1,2,3 on consecutive cycles with id_valid=1 and id_pc_plus1=id_pc+1.
REQ-034 stall=1 for 3 cycles coincident with a response at pc=5: state HOLD, imem_req=0, IF/ID unchanged; one cycle after stall falls id_instr = word@5 and pc=6.
REQ-035 kill=1, pc_src=2, branch_target=16'h0040 while imem_ready=1: next cycle id_valid=0, id_instr=NOP_INSTR, pc=16'h0040, imem_addr=16'h0040.
REQ-036 kill=1, pc_src=3, return_addr=16'h0123 with imem_ready=0 at addr 16'h0010: DROP holds imem_addr=16'h0010 until ready; that data is never written to IF/ID; the next fetch is at 16'h0123.
REQ-037 RESET_PC=16'hFFFF, one fetch: pc wraps to 16'h0000 and id_pc_plus1=16'h0000.
REQ-038 stall=1 and kill=1 in the same cycle with pc_src=1 and jump_target=16'h0200: flush occurs and pc=16'h0200.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, imem request, and the IF/ID register.
// A one-entry skid buffer absorbs responses that arrive while decode stalls.
module fetch_stage #(
  parameter int              PC_W      = 16,
  parameter int              INSTR_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               kill,
  input  logic [1:0]         pc_src,
  input  logic [PC_W-1:0]    jump_target,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [PC_W-1:0]    return_addr,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  output logic [PC_W-1:0]    id_pc_plus1,
  output logic               id_valid,
  output logic [PC_W-1:0]    pc
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HOLD,
    DROP
  } state_t;

  state_t               state;
  logic [INSTR_W-1:0]   skid;
  logic                 skid_vld;
  logic [PC_W-1:0]      drop_addr;
  logic [PC_W-1:0]      pc_inc;
  logic [PC_W-1:0]      redir_pc;

  assign pc_inc = pc + PC_W'(1);

  always_comb begin
    redir_pc = pc_inc;
    unique case (pc_src)
      2'd0: redir_pc = pc_inc;
      2'd1: redir_pc = jump_target;
      2'd2: redir_pc = branch_target;
      2'd3: redir_pc = return_addr;
    endcase
  end

  // Request lines depend only on registered state.
  assign imem_req  = (state == FETCH) || (state == DROP);
  assign imem_addr = (state == DROP) ? drop_addr : pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      skid        <= NOP_INSTR;
      skid_vld    <= 1'b0;
      drop_addr   <= '0;
      id_instr    <= NOP_INSTR;
      id_pc       <= '0;
      id_pc_plus1 <= '0;
      id_valid    <= 1'b0;
    end else begin
      unique case (state)
        BOOT: begin
          if (kill) begin
            id_instr <= NOP_INSTR;
            id_valid <= 1'b0;
            pc       <= redir_pc;
          end
          state <= FETCH;
        end
        FETCH: begin
          if (kill) begin
            id_instr <= NOP_INSTR;
            id_valid <= 1'b0;
            skid_vld <= 1'b0;
            pc       <= redir_pc;
            if (!imem_ready) begin
              drop_addr <= pc;
              state     <= DROP;
            end
          end else if (imem_ready) begin
            if (stall) begin
              skid     <= imem_rdata;
              skid_vld <= 1'b1;
              state    <= HOLD;
            end else begin
              id_instr    <= imem_rdata;
              id_pc       <= pc;
              id_pc_plus1 <= pc_inc;
              id_valid    <= 1'b1;
              pc          <= pc_inc;
            end
          end
        end
        HOLD: begin
          if (kill) begin
            id_instr <= NOP_INSTR;
            id_valid <= 1'b0;
            skid_vld <= 1'b0;
            pc       <= redir_pc;
            state    <= FETCH;
          end else if (!stall) begin
            id_instr    <= skid_vld ? skid : NOP_INSTR;
            id_pc       <= pc;
            id_pc_plus1 <= pc_inc;
            id_valid    <= skid_vld;
            skid_vld    <= 1'b0;
            pc          <= pc_inc;
            state       <= FETCH;
          end
        end
        DROP: begin
          // IF/ID is already flushed here; the stale response is discarded.
          if (kill) pc <= redir_pc;
          if (imem_ready) state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scenario bench for fetch_stage: scoreboarded fetch stream plus
// stall, kill, drop, reset and PC wrap scenarios.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n = 1'b1;
  logic        stall;
  logic        kill;
  logic [1:0]  pc_src;
  logic [15:0] jump_target;
  logic [15:0] branch_target;
  logic [15:0] return_addr;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic [15:0] id_pc_plus1;
  logic        id_valid;
  logic [15:0] pc;

  logic        u2_req;
  logic [15:0] u2_addr;
  logic [15:0] u2_rdata;
  logic [15:0] u2_instr;
  logic [15:0] u2_id_pc;
  logic [15:0] u2_pc1;
  logic        u2_valid;
  logic [15:0] u2_pc;

  logic [15:0] key;
  logic [15:0] mpc;
  int          n_pass = 0;
  int          n_total = 0;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc1;
  } exp_t;

  exp_t sb[$];
  exp_t lst;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .kill(kill),
    .pc_src(pc_src), .jump_target(jump_target),
    .branch_target(branch_target), .return_addr(return_addr),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus1(id_pc_plus1),
    .id_valid(id_valid), .pc(pc)
  );

  fetch_stage #(.RESET_PC(16'hFFFF)) u_wrap (
    .clk(clk), .rst_n(rst_n), .stall(stall), .kill(kill),
    .pc_src(pc_src), .jump_target(jump_target),
    .branch_target(branch_target), .return_addr(return_addr),
    .imem_req(u2_req), .imem_addr(u2_addr),
    .imem_ready(imem_ready), .imem_rdata(u2_rdata),
    .id_instr(u2_instr), .id_pc(u2_id_pc), .id_pc_plus1(u2_pc1),
    .id_valid(u2_valid), .pc(u2_pc)
  );

  // Memory model: word at address a is a ^ key.
  always_comb imem_rdata = imem_addr ^ key;
  always_comb u2_rdata = u2_addr ^ key;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic pop_check(input string nm);
    exp_t e;
    n_total++;
    if (sb.size() == 0) begin
      $display("FAIL %s_sb: scoreboard empty", nm);
      return;
    end
    e = sb.pop_front();
    lst = e;
    if (id_valid !== 1'b1 || id_instr !== e.instr || id_pc !== e.pc || id_pc_plus1 !== e.pc1)
      $display("FAIL %s: got v=%0b i=%h pc=%h p1=%h want v=1 i=%h pc=%h p1=%h",
               nm, id_valid, id_instr, id_pc, id_pc_plus1, e.instr, e.pc, e.pc1);
    else n_pass++;
  endtask

  task automatic test_reset();
    stall = 0; kill = 0; pc_src = 0; imem_ready = 0; key = 16'h0000;
    jump_target = 0; branch_target = 0; return_addr = 0;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else n_pass++;
    n_total++; if (id_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", id_valid); else n_pass++;
    n_total++; if (id_instr !== 16'h0) $display("FAIL rst_instr: got %h want 0000", id_instr); else n_pass++;
    n_total++; if (id_pc !== 16'h0 || id_pc_plus1 !== 16'h0) $display("FAIL rst_idpc: got %h/%h want 0/0", id_pc, id_pc_plus1); else n_pass++;
    n_total++; if (pc !== 16'h0) $display("FAIL rst_pc: got %h want 0000", pc); else n_pass++;
    n_total++; if (u2_pc !== 16'hFFFF) $display("FAIL rst_pc2: got %h want ffff", u2_pc); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_total++; if (imem_req !== 1'b0) $display("FAIL boot_req: got %b want 0", imem_req); else n_pass++;
    @(negedge clk);
    n_total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0) $display("FAIL first_req: got %b@%h want 1@0000", imem_req, imem_addr); else n_pass++;
  endtask

  task automatic test_stream();
    key = 16'h0000;
    mpc = 16'h0000;
    imem_ready = 1;
    for (int i = 0; i < 5; i++) begin
      n_total++; if (imem_req !== 1'b1 || imem_addr !== mpc) $display("FAIL stream_addr: got %b@%h want 1@%h", imem_req, imem_addr, mpc); else n_pass++;
      sb.push_back('{instr: mpc ^ key, pc: mpc, pc1: mpc + 16'd1});
      @(negedge clk);
      pop_check("stream");
      mpc = mpc + 16'd1;
    end
    imem_ready = 0;
    n_total++; if (pc !== 16'd5) $display("FAIL stream_pc: got %h want 0005", pc); else n_pass++;
  endtask

  task automatic test_stall_skid();
    key = 16'hC3C3;
    imem_ready = 1; stall = 1;
    sb.push_back('{instr: 16'd5 ^ key, pc: 16'd5, pc1: 16'd6});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      imem_ready = 0;
      n_total++; if (imem_req !== 1'b0) $display("FAIL hold_req: got %b want 0", imem_req); else n_pass++;
      n_total++; if (id_instr !== lst.instr || id_pc !== lst.pc || pc !== 16'd5) $display("FAIL hold_keep: got i=%h pc=%h fpc=%h want i=%h pc=%h fpc=0005", id_instr, id_pc, pc, lst.instr, lst.pc); else n_pass++;
    end
    stall = 0;
    @(negedge clk);
    pop_check("skid");
    n_total++; if (pc !== 16'd6 || imem_req !== 1'b1 || imem_addr !== 16'd6) $display("FAIL skid_pc: got %h req=%b@%h want 0006 1@0006", pc, imem_req, imem_addr); else n_pass++;
  endtask

  task automatic test_kill_branch();
    imem_ready = 1; kill = 1; pc_src = 2; branch_target = 16'h0040;
    @(negedge clk);
    kill = 0; imem_ready = 0;
    n_total++; if (id_valid !== 1'b0 || id_instr !== 16'h0) $display("FAIL br_flush: got v=%b i=%h want 0/0000", id_valid, id_instr); else n_pass++;
    n_total++; if (pc !== 16'h0040 || imem_addr !== 16'h0040 || imem_req !== 1'b1) $display("FAIL br_pc: got %h addr=%h req=%b want 0040", pc, imem_addr, imem_req); else n_pass++;
    n_total++; if (id_pc !== 16'd5 || id_pc_plus1 !== 16'd6) $display("FAIL br_idpc: got %h/%h want 0005/0006", id_pc, id_pc_plus1); else n_pass++;
  endtask

  task automatic test_kill_drop();
    imem_ready = 1; kill = 1; pc_src = 1; jump_target = 16'h0010;
    @(negedge clk);
    imem_ready = 0; pc_src = 3; return_addr = 16'h0123;
    n_total++; if (imem_addr !== 16'h0010) $display("FAIL jmp_addr: got %h want 0010", imem_addr); else n_pass++;
    @(negedge clk);
    kill = 0;
    n_total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0010 || pc !== 16'h0123) $display("FAIL drop_addr: got %b@%h pc=%h want 1@0010 pc=0123", imem_req, imem_addr, pc); else n_pass++;
    @(negedge clk);
    n_total++; if (imem_addr !== 16'h0010 || id_valid !== 1'b0) $display("FAIL drop_wait: got %h v=%b want 0010 v=0", imem_addr, id_valid); else n_pass++;
    imem_ready = 1;
    @(negedge clk);
    n_total++; if (id_valid !== 1'b0 || id_instr !== 16'h0) $display("FAIL drop_discard: got v=%b i=%h want 0/0000", id_valid, id_instr); else n_pass++;
    n_total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0123) $display("FAIL drop_next: got %b@%h want 1@0123", imem_req, imem_addr); else n_pass++;
    sb.push_back('{instr: 16'h0123 ^ key, pc: 16'h0123, pc1: 16'h0124});
    @(negedge clk);
    imem_ready = 0;
    pop_check("after_drop");
  endtask

  task automatic test_stall_kill();
    stall = 1; imem_ready = 0;
    @(negedge clk);
    n_total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0124 || id_pc !== 16'h0123 || id_valid !== 1'b1) $display("FAIL wait_stall: got %b@%h idpc=%h v=%b want 1@0124 0123 1", imem_req, imem_addr, id_pc, id_valid); else n_pass++;
    kill = 1; imem_ready = 1; pc_src = 1; jump_target = 16'h0200;
    @(negedge clk);
    kill = 0; stall = 0;
    n_total++; if (id_valid !== 1'b0 || id_instr !== 16'h0 || id_pc !== 16'h0123) $display("FAIL sk_flush: got v=%b i=%h pc=%h want 0 0000 0123", id_valid, id_instr, id_pc); else n_pass++;
    n_total++; if (pc !== 16'h0200) $display("FAIL sk_pc: got %h want 0200", pc); else n_pass++;
    kill = 1; pc_src = 0;
    @(negedge clk);
    kill = 0; imem_ready = 0;
    n_total++; if (pc !== 16'h0201 || imem_addr !== 16'h0201 || id_valid !== 1'b0) $display("FAIL kill_inc: got %h@%h v=%b want 0201 v=0", pc, imem_addr, id_valid); else n_pass++;
  endtask

  task automatic test_hold_kill();
    imem_ready = 1; stall = 1;
    @(negedge clk);
    imem_ready = 0;
    n_total++; if (imem_req !== 1'b0) $display("FAIL hk_hold: got %b want 0", imem_req); else n_pass++;
    kill = 1; pc_src = 2; branch_target = 16'h0300;
    @(negedge clk);
    kill = 0; stall = 0;
    n_total++; if (pc !== 16'h0300 || imem_req !== 1'b1 || id_valid !== 1'b0) $display("FAIL hk_kill: got %h req=%b v=%b want 0300 1 0", pc, imem_req, id_valid); else n_pass++;
    @(negedge clk);
    n_total++; if (id_valid !== 1'b0 || pc !== 16'h0300) $display("FAIL hk_skid: got v=%b pc=%h want 0 0300", id_valid, pc); else n_pass++;
  endtask

  task automatic test_reset_mid();
    imem_ready = 1;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (imem_req !== 1'b0 || id_valid !== 1'b0 || pc !== 16'h0) $display("FAIL mid_rst: got req=%b v=%b pc=%h want 0 0 0000", imem_req, id_valid, pc); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0 || id_valid !== 1'b0) $display("FAIL mid_boot: got %b@%h v=%b want 1@0000 v=0", imem_req, imem_addr, id_valid); else n_pass++;
  endtask

  task automatic test_wrap();
    n_total++; if (u2_req !== 1'b1 || u2_addr !== 16'hFFFF) $display("FAIL wrap_req: got %b@%h want 1@ffff", u2_req, u2_addr); else n_pass++;
    @(negedge clk);
    imem_ready = 0;
    n_total++; if (u2_pc !== 16'h0000 || u2_pc1 !== 16'h0000) $display("FAIL wrap_pc: got %h p1=%h want 0000/0000", u2_pc, u2_pc1); else n_pass++;
    n_total++; if (u2_valid !== 1'b1 || u2_id_pc !== 16'hFFFF || u2_instr !== (16'hFFFF ^ key)) $display("FAIL wrap_id: got v=%b pc=%h i=%h want 1 ffff %h", u2_valid, u2_id_pc, u2_instr, 16'hFFFF ^ key); else n_pass++;
    n_total++; if (id_valid !== 1'b1 || id_pc !== 16'h0 || id_instr !== key) $display("FAIL post_rst_fetch: got v=%b pc=%h i=%h want 1 0000 %h", id_valid, id_pc, id_instr, key); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_skid();
    test_kill_branch();
    test_kill_drop();
    test_stall_kill();
    test_hold_kill();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
